// File: rtl/xosera_bus_writer.sv
// Host-side write sequencer for the Xosera 8-bit register bus: queues 16-bit
// register writes and replays them as one or two timed byte cycles.
module xosera_bus_writer #(
    parameter int REG_W      = 4,
    parameter int DEPTH      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    // Write stream: a write is taken on a clock edge where wr_valid_i and
    // wr_ready_o are both high; the source holds its payload stable until then.
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [REG_W-1:0]         wr_reg_i,
    input  logic [15:0]              wr_data_i,
    input  logic [1:0]               wr_mask_i,
    output logic                     bus_cs_n_o,
    output logic                     bus_rd_nwr_o,
    output logic [REG_W-1:0]         bus_reg_num_o,
    output logic                     bus_bytesel_o,
    output logic [7:0]               bus_data_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [1:0]               dbg_state
);
    localparam int AW      = $clog2(DEPTH);
    localparam int EW      = REG_W + 18;
    localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level;
    logic             push, pop, empty, full;
    logic [EW-1:0]    head;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_ld;
    logic             cnt_done, load_entry, next_low;
    logic [REG_W-1:0] cur_reg;
    logic [15:0]      cur_data;
    logic             cur_lo, cur_sel;

    assign full       = (level == (AW+1)'(DEPTH));
    assign empty      = (level == '0);
    assign wr_ready_o = !full;
    // A write with no byte enables is acknowledged but never queued.
    assign push       = wr_valid_i && !full && (wr_mask_i != 2'b00);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wr_reg_i, wr_data_i, wr_mask_i};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign cnt_done = (cnt == '0);

    always_comb begin
        state_d    = state;
        pop        = 1'b0;
        load_entry = 1'b0;
        next_low   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    load_entry = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP:  if (cnt_done) state_d = STROBE;
            STROBE: if (cnt_done) state_d = HOLD;
            HOLD: begin
                if (cnt_done) begin
                    if (!cur_sel && cur_lo) begin
                        next_low = 1'b1;
                        state_d  = SETUP;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        load_entry = 1'b1;
                        state_d    = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_ld = '0;
        case (state_d)
            SETUP:   cnt_ld = SETUP_LD;
            STROBE:  cnt_ld = STROBE_LD;
            HOLD:    cnt_ld = HOLD_LD;
            default: cnt_ld = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            if (state_d != state) cnt <= cnt_ld;
            else if (!cnt_done)   cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_reg  <= '0;
            cur_data <= '0;
            cur_lo   <= 1'b0;
            cur_sel  <= 1'b0;
        end else if (load_entry) begin
            cur_reg  <= head[EW-1 -: REG_W];
            cur_data <= head[17:2];
            cur_lo   <= head[0];
            cur_sel  <= !head[1];
        end else if (next_low) begin
            cur_sel  <= 1'b1;
        end
    end

    // Bus pins trail the FSM by one register stage; in IDLE the address and
    // data simply keep their last driven values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_cs_n_o    <= 1'b1;
            bus_reg_num_o <= '0;
            bus_bytesel_o <= 1'b0;
            bus_data_o    <= '0;
        end else begin
            bus_cs_n_o <= (state != STROBE);
            if (state != IDLE) begin
                bus_reg_num_o <= cur_reg;
                bus_bytesel_o <= cur_sel;
                bus_data_o    <= cur_sel ? cur_data[7:0] : cur_data[15:8];
            end
        end
    end

    assign bus_rd_nwr_o = 1'b0;
    assign busy_o       = (state != IDLE) || (level != '0);
    assign level_o      = level;
    assign dbg_state    = state;
endmodule

// File: tb/tb_xosera_bus_writer.sv
// Bench for xosera_bus_writer: scoreboarded byte cycles on the default
// instance plus directed timing checks on a 3/1/2 timing instance.
module tb_xosera_bus_writer;
    localparam int REG_W = 4;
    localparam int DEPTH = 8;
    localparam int W     = REG_W + 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             wr_valid = 1'b0, wr_ready;
    logic [REG_W-1:0] wr_reg = '0;
    logic [15:0]      wr_data = '0;
    logic [1:0]       wr_mask = '0;
    logic             cs_n, rd_nwr, bytesel, busy;
    logic [REG_W-1:0] reg_num;
    logic [7:0]       data;
    logic [3:0]       level;
    logic [1:0]       dbg;

    logic             wr_valid2 = 1'b0, wr_ready2;
    logic [REG_W-1:0] wr_reg2 = '0;
    logic [15:0]      wr_data2 = '0;
    logic [1:0]       wr_mask2 = '0;
    logic             cs_n2, rd_nwr2, bytesel2, busy2;
    logic [REG_W-1:0] reg_num2;
    logic [7:0]       data2;
    logic [3:0]       level2;
    logic [1:0]       dbg2;

    xosera_bus_writer #(.REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_reg_i(wr_reg),
        .wr_data_i(wr_data), .wr_mask_i(wr_mask),
        .bus_cs_n_o(cs_n), .bus_rd_nwr_o(rd_nwr), .bus_reg_num_o(reg_num),
        .bus_bytesel_o(bytesel), .bus_data_o(data), .busy_o(busy),
        .level_o(level), .dbg_state(dbg)
    );

    xosera_bus_writer #(.REG_W(REG_W), .DEPTH(DEPTH), .SETUP_CYC(3),
                        .STROBE_CYC(1), .HOLD_CYC(2)) dut2 (
        .clk(clk), .reset_n(rst_n),
        .wr_valid_i(wr_valid2), .wr_ready_o(wr_ready2), .wr_reg_i(wr_reg2),
        .wr_data_i(wr_data2), .wr_mask_i(wr_mask2),
        .bus_cs_n_o(cs_n2), .bus_rd_nwr_o(rd_nwr2), .bus_reg_num_o(reg_num2),
        .bus_bytesel_o(bytesel2), .bus_data_o(data2), .busy_o(busy2),
        .level_o(level2), .dbg_state(dbg2)
    );

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every falling cs_n is one bus byte, checked against the queue.
    logic         prev_cs = 1'b1;
    logic         have_prev = 1'b0;
    logic         gap_en = 1'b0;
    int           low_cnt = 0;
    int           high_cnt = 0;
    logic [W-1:0] start_w = '0;
    logic [W-1:0] exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs   = 1'b1;
            have_prev = 1'b0;
            low_cnt   = 0;
            high_cnt  = 0;
        end else begin
            if (!cs_n && prev_cs) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%0h want none", {reg_num, bytesel, data});
                end else begin
                    exp_w = exp_q.pop_front();
                    check("bus_byte", int'({reg_num, bytesel, data}), int'(exp_w));
                end
                check("rd_nwr", int'(rd_nwr), 0);
                if (gap_en && have_prev) check("cs_gap", high_cnt, 2);
                start_w = {reg_num, bytesel, data};
                low_cnt = 1;
            end else if (!cs_n) begin
                low_cnt++;
                check("strobe_stable", int'({reg_num, bytesel, data}), int'(start_w));
            end else if (!prev_cs) begin
                check("strobe_len", low_cnt, 2);
                high_cnt  = 1;
                have_prev = 1'b1;
            end else begin
                high_cnt++;
            end
            prev_cs = cs_n;
        end
    end

    task automatic push(input logic [3:0] r, input logic [15:0] d, input logic [1:0] m);
        int n;
        wr_reg = r;
        wr_data = d;
        wr_mask = m;
        wr_valid = 1'b1;
        if (m[1]) exp_q.push_back({r, 1'b0, d[15:8]});
        if (m[0]) exp_q.push_back({r, 1'b1, d[7:0]});
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!wr_ready) check("push_timeout", int'(wr_ready), 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        check(name, int'(busy), 0);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int first, drop, lows;
        logic [W-1:0] seen;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_data", int'(data), 0);
        check("rst_reg_bytesel", int'({reg_num, bytesel}), 0);
        check("rst_level", int'(level), 0);
        check("rst_ready", int'(wr_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_cs_n2", int'(cs_n2), 1);
        @(posedge clk);
        #1;

        // Single two-byte write: latency and busy duration.
        push(4'hA, 16'h1234, 2'b11);
        first = 0;
        drop = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (first == 0 && !cs_n) first = k;
            if (!busy) begin
                drop = k;
                break;
            end
        end
        check("first_low_lat", first, 3);
        check("busy_drop", drop, 9);
        check("drain_single", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Byte masks.
        push(4'h2, 16'hABCD, 2'b01);
        wait_idle("idle_mask01");
        @(posedge clk);
        #1;
        push(4'h2, 16'hABCD, 2'b10);
        wait_idle("idle_mask10");
        @(posedge clk);
        #1;
        push(4'h7, 16'hFFFF, 2'b00);
        lows = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!cs_n) lows++;
        end
        check("mask00_lows", lows, 0);
        check("mask00_level", int'(level), 0);
        check("mask00_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Fill the FIFO behind an active transfer; all bytes back-to-back.
        gap_en = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 9; i++)
            push(4'(i), {8'(i * 17), 8'(i + 64)}, 2'b11);
        @(negedge clk);
        check("full_level", int'(level), 8);
        check("full_ready", int'(wr_ready), 0);
        push(4'hF, 16'hBEEF, 2'b11);
        wait_idle("idle_fill");
        gap_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a strobe with three entries queued.
        for (int i = 0; i < 4; i++)
            push(4'(i + 8), {8'(i + 160), 8'(i + 176)}, 2'b11);
        lows = 0;
        @(negedge clk);
        while (cs_n && lows < 50) begin
            lows++;
            @(negedge clk);
        end
        check("pre_reset_cs_n", int'(cs_n), 0);
        check("pre_reset_level", int'(level), 3);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_cs_n", int'(cs_n), 1);
        check("abort_level", int'(level), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(wr_ready), 1);
        #1;
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!cs_n) lows++;
        end
        check("abort_no_cycles", lows, 0);
        @(posedge clk);
        #1;
        push(4'h3, 16'h5678, 2'b11);
        wait_idle("idle_after_abort");

        // 3/1/2 timing instance, single high-byte write.
        @(posedge clk);
        #1;
        wr_reg2 = 4'h5;
        wr_data2 = 16'h9A55;
        wr_mask2 = 2'b10;
        wr_valid2 = 1'b1;
        @(negedge clk);
        check("t2_ready", int'(wr_ready2), 1);
        @(posedge clk);
        #1;
        wr_valid2 = 1'b0;
        first = 0;
        drop = 0;
        lows = 0;
        seen = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!cs_n2) begin
                lows++;
                seen = {reg_num2, bytesel2, data2};
                if (first == 0) first = k;
            end
            if (!busy2) begin
                drop = k;
                break;
            end
        end
        check("t2_first_low", first, 5);
        check("t2_low_len", lows, 1);
        check("t2_busy_drop", drop, 7);
        check("t2_byte", int'(seen), int'({4'h5, 1'b0, 8'h9A}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xosera_bus_writer.md
Name: xosera_bus_writer

Overview:
- Host-side write sequencer for the Xosera 8-bit register bus.
- Accepts full-width register writes on a valid/ready stream and buffers them in a parametrised FIFO.
- Emits each write as one or two byte-wide bus cycles: high byte with bytesel=0, low byte with bytesel=1, with programmable setup/strobe/hold timing.
- Sits between a CPU/test stimulus and xosera_main bus inputs; replaces hand-driven cs_n/bytesel pins in top-level.

Parameters:
- REG_W, 4: register-number width.
- DEPTH, 8: FIFO entries; power of 2, >=2.
- SETUP_CYC, 1: cycles address/data driven with cs_n high before strobe; >=1.
- STROBE_CYC, 2: cycles cs_n low per byte; >=1.
- HOLD_CYC, 1: cycles address/data held with cs_n high after strobe; >=1.

Ports:
- clk, in, 1: single clock (pixel clock domain).
- reset_n, in, 1: synchronous, active-low reset.
- wr_valid_i, in, 1: write request valid.
- wr_ready_o, out, 1: FIFO can accept; equals !full.
- wr_reg_i, in, REG_W: target register number.
- wr_data_i, in, 16: write data; [15:8] high byte, [7:0] low byte.
- wr_mask_i, in, 2: byte enables; bit1 = high, bit0 = low.
- bus_cs_n_o, out, 1: bus chip select, active-low.
- bus_rd_nwr_o, out, 1: constant 0 (write-only).
- bus_reg_num_o, out, REG_W: register number.
- bus_bytesel_o, out, 1: 0 = high byte, 1 = low byte.
- bus_data_o, out, 8: byte data.
- busy_o, out, 1: FSM not IDLE or FIFO non-empty.
- level_o, out, clog2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (reset_n=0 sampled at edge):
  - bus_cs_n_o=1; bus_reg_num_o, bus_bytesel_o, bus_data_o = 0.
  - FSM to IDLE; FIFO flushed; level_o=0; busy_o=0; wr_ready_o=1.
  - Mid-transfer reset aborts immediately: cs_n high on the next cycle; partial byte discarded.
- All bus outputs are registered; bus_rd_nwr_o is tied 0.
- Push occurs when wr_valid_i && wr_ready_o at the edge.
  - Entries with wr_mask_i=2'b00 are accepted but not stored: level unchanged, no bus activity.
- FIFO:
  - wr_ready_o low when level==DEPTH.
  - Simultaneous push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - cs_n=1.
  - If FIFO non-empty: pop head, latch reg/data/mask, select first byte (high if mask[1], else low), go to SETUP.
- SETUP:
  - Drive reg_num, bytesel and the byte; cs_n=1.
  - Stay SETUP_CYC cycles, then go to STROBE.
- STROBE: cs_n=0 for exactly STROBE_CYC cycles, then go to HOLD. Address/data stable.
- HOLD: cs_n=1 with address/data stable for HOLD_CYC cycles. Then:
  - If high byte just finished and mask[0]=1: go to SETUP for the low byte (bytesel=1).
  - Else if FIFO non-empty: pop the next entry and go to SETUP directly, with no IDLE cycle.
  - Else go to IDLE.
  - Outputs keep their last values in IDLE.
- Per-byte length is SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
- Latency: a push into an empty FIFO while IDLE → SETUP begins on the cycle after next. First cs_n low is 2+SETUP_CYC cycles after the accepting edge.
- Phase counter width is clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1) bits; it reloads on every state change.
- busy_o = (state!=IDLE) || (level_o!=0).

Test Plan:
- Reset, no stimulus:
  - cs_n=1, data=0, level_o=0, wr_ready_o=1, busy_o=0.
- Single write, defaults (1/2/1), reg=4'hA, data=16'h12_34, mask=2'b11:
  - Two 4-cycle byte sequences.
  - cs_n low 2 cycles with bytesel=0, data=8'h12.
  - Then cs_n low 2 cycles with bytesel=1, data=8'h34, reg_num=4'hA throughout.
  - First cs_n low 3 cycles after accept; busy_o drops after 8 bus cycles.
- Byte masks:
  - mask=2'b01, data=16'hABCD → one byte, bytesel=1, data=8'hCD.
  - mask=2'b10 → one byte, bytesel=0, data=8'hAB.
  - mask=2'b00 → no cs_n activity, level_o stays 0.
- Fill FIFO with DEPTH=8 writes while the first is transferring:
  - wr_ready_o deasserts at level 8.
  - Push held until a pop; valid held across the stall is accepted once.
  - All 8 writes emerge in order, back-to-back, with no IDLE gap (cs_n high exactly HOLD+SETUP=2 cycles between strobes).
- Reset mid-STROBE with 3 entries queued:
  - cs_n=1 next cycle; level_o=0; no further bus cycles.
  - A new write afterward transfers normally.
- SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2, single mask=2'b10 write:
  - cs_n low exactly 1 cycle, 5 cycles after accept.
  - Byte window is 6 cycles.
